multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Moore FSM that sequences a multicycle RV32I datapath: shared instr/data memory, IR, OldPC, ALUOut and Data regs.
//  Decodes lw, sw, R-type, I-ALU, beq and jal, then drives mux selects and write strobes each cycle.
//  Stalls on a memory ready handshake. Reuses the existing alu_decoder for ALUControl.
// PARAMETERS
//  HALT_ON_ILLEGAL  1   1: ILLEGAL state is sticky until reset; 0: return to FETCH after one cycle
//  CNT_W            32  width of the performance counters (only with MC_PERF_CNT_EN)
// PORTS
//  clk        in   1  single clock; all state changes on posedge
//  rst_n      in   1  asynchronous, active-low reset
//  op         in   7  Inst[6:0] from IR
//  funct3     in   3  Inst[14:12]
//  funct7     in   1  Inst[30]
//  zero       in   1  ALU zero flag
//  mem_ready  in   1  memory completes the access this cycle (tie 1 for single-cycle memory)
//  mem_req    out  1  memory access in progress (FETCH, MEMREAD, MEMWRITE)
//  PCWrite    out  1  PC write enable = (PCUpdate | (Branch & zero))
//  AdrSrc     out  1  memory address: 0=PC, 1=Result
//  MemWrite   out  1  data store strobe
//  IRWrite    out  1  IR and OldPC load
//  RegWrite   out  1  register file write
//  ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult
//  ALUSrcA    out  2  00=PC, 01=OldPC, 10=RD1
//  ALUSrcB    out  2  00=RD2, 01=ImmExt, 10=const 4
//  ImmSrc     out  2  combinational from op: I=00, S=01, B=10, J=11 (don't-care: 00)
//  ALUControl out  3  000 add, 001 sub, 010 and, 011 or, 101 slt
//  illegal    out  1  high while the FSM is in ILLEGAL
// BEHAVIOUR
//  Reset: state=FETCH. While rst_n=0, all strobes (PCWrite, IRWrite, RegWrite, MemWrite) and illegal are 0.
//  Reset can hit mid-access: MemWrite drops asynchronously. No partial-instruction state survives reset.
//  Unlisted outputs are 0 in every state. ALUOp is internal: 00 add, 01 sub (beq), 10 funct-decoded.
//  FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, mem_req=1.
//    IRWrite and PCUpdate are asserted only when mem_ready=1. Go to DECODE on mem_ready, else hold.
//  DECODE: ALUSrcA=01, ALUSrcB=01 (branch/jump target into ALUOut). Next state by op:
//    0000011/0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ;
//    1101111 -> JAL; any other op -> ILLEGAL.
//  MEMADR: ALUSrcA=10, ALUSrcB=01 -> MEMREAD (op[5]=0) or MEMWRITE (op[5]=1).
//  MEMREAD: AdrSrc=1, mem_req=1; hold until mem_ready -> MEMWB.
//  MEMWB: ResultSrc=01, RegWrite=1 -> FETCH.
//  MEMWRITE: AdrSrc=1, MemWrite=1, mem_req=1. MemWrite stays high until mem_ready, then -> FETCH.
//  EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10 -> ALUWB.
//  EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10 -> ALUWB.
//  ALUWB: ResultSrc=00, RegWrite=1 -> FETCH.
//  BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1 -> FETCH.
//  JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1 -> ALUWB (rd <- PC+4).
//  ILLEGAL: illegal=1, no strobes. HALT_ON_ILLEGAL=1: stay until reset; 0: -> FETCH.
//  ALUControl: the funct7 input to alu_decoder is gated by op[5], so I-type (addi) never decodes as sub.
//  Latency in cycles with mem_ready=1: lw 5, sw 4, R/I 4, jal 4, beq 3.
//    Each mem_ready=0 cycle adds one cycle.
// CONFIGURATION
//  MC_PERF_CNT_EN defined: adds outputs cycle_cnt[CNT_W-1:0] and instret_cnt[CNT_W-1:0].
//    Both reset to 0 and wrap modulo 2^CNT_W.
//    cycle_cnt increments every cycle out of reset.
//    instret_cnt increments on each exit from MEMWB, MEMWRITE (on mem_ready), ALUWB or BEQ.
//  Undefined: both ports and counters are absent; FSM behaviour is identical.
// STRUCTURE
//  Shared package mc_pkg holds: state enum (FETCH..ILLEGAL, 4-bit), opcode constants,
//  ALUOp/ResultSrc/ALUSrcA/ALUSrcB encodings.
//  Sub-module: instantiate the existing alu_decoder. FSM, ImmSrc decode and counters stay in this file.
// TESTING
//  1. add 0x002081B3, mem_ready=1 -> FETCH,DECODE,EXECUTER,ALUWB; RegWrite only in cycle 4; ALUControl=000.
//  2. sub 0x402081B3 -> ALUControl=001. addi 0x40008093 -> ALUControl=000 (funct7 gated).
//  3. lw 0x0000A183 with mem_ready=0 for 3 cycles in MEMREAD -> state held, RegWrite=0;
//     MEMWB follows ready; 8 cycles total.
//  4. beq 0x00208463: zero=1 -> PCWrite=1 in BEQ; zero=0 -> PCWrite=0; both return to FETCH in cycle 4.
//  5. op=0x7F -> ILLEGAL with illegal=1, no strobes; with HALT_ON_ILLEGAL=1, still ILLEGAL after 10 cycles.
//  6. rst_n=0 mid-MEMWRITE -> MemWrite=0 immediately; after release, FETCH with mem_req=1, AdrSrc=0.
//     With MEMWRITE=0 and MC_PERF_CNT_EN, add,sw,beq -> instret_cnt=3, cycle_cnt=11.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle RV32I control unit: FSM states, opcodes, mux selects.
// No logic here beyond the ImmSrc helper, which is purely combinational.
// No handshakes of its own; consumers own the flow control.
package mc_pkg;

    typedef logic [3:0] state_t;

    localparam state_t FETCH    = 4'd0;
    localparam state_t DECODE   = 4'd1;
    localparam state_t MEMADR   = 4'd2;
    localparam state_t MEMREAD  = 4'd3;
    localparam state_t MEMWB    = 4'd4;
    localparam state_t MEMWRITE = 4'd5;
    localparam state_t EXECUTER = 4'd6;
    localparam state_t EXECUTEI = 4'd7;
    localparam state_t ALUWB    = 4'd8;
    localparam state_t BEQ      = 4'd9;
    localparam state_t JAL      = 4'd10;
    localparam state_t ILLEGAL  = 4'd11;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_t;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    function automatic logic [1:0] imm_src(input logic [6:0] opcode);
        logic [1:0] sel;
        case (opcode)
            OP_STORE:  sel = 2'b01;
            OP_BRANCH: sel = 2'b10;
            OP_JAL:    sel = 2'b11;
            default:   sel = 2'b00;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation select from ALUOp and the instruction function fields.
// Combinational, zero cycles; funct7b5 arrives already qualified by the caller.
// No backpressure: pure decode.
module alu_decoder
    import mc_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = 3'b000;
        case (alu_op)
            ALUOP_ADD: alu_control = 3'b000;
            ALUOP_SUB: alu_control = 3'b001;
            default: begin
                case (funct3)
                    3'b000:  alu_control = funct7b5 ? 3'b001 : 3'b000;
                    3'b010:  alu_control = 3'b101;
                    3'b110:  alu_control = 3'b011;
                    3'b111:  alu_control = 3'b010;
                    default: alu_control = 3'b000;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore FSM sequencing a multicycle RV32I datapath; MC_PERF_CNT_EN adds cycle/instret counters.
// Latency with ready memory: lw 5, sw 4, R/I 4, jal 4, beq 3 cycles.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold while mem_ready is low.
module multicycle_control_unit
    import mc_pkg::*;
#(
    parameter bit HALT_ON_ILLEGAL = 1'b1
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal
`ifdef MC_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
`endif
);

    state_t  state;
    state_t  state_nxt;
    alu_op_t alu_op;
    logic    pc_update;
    logic    branch;
    logic    ir_write_raw;
    logic    reg_write_raw;
    logic    mem_write_raw;
    logic    illegal_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        alu_op        = ALUOP_ADD;
        pc_update     = 1'b0;
        branch        = 1'b0;
        ir_write_raw  = 1'b0;
        reg_write_raw = 1'b0;
        mem_write_raw = 1'b0;
        illegal_raw   = 1'b0;
        mem_req       = 1'b0;
        AdrSrc        = 1'b0;
        ResultSrc     = RES_ALUOUT;
        ALUSrcA       = SRCA_PC;
        ALUSrcB       = SRCB_RD2;
        case (state)
            FETCH: begin
                mem_req      = 1'b1;
                ALUSrcB      = SRCB_FOUR;
                ResultSrc    = RES_ALURES;
                ir_write_raw = mem_ready;
                pc_update    = mem_ready;
                if (mem_ready) state_nxt = DECODE;
            end
            DECODE: begin
                // Branch/jump target is precomputed into ALUOut here.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_nxt = MEMADR;
                    OP_RTYPE:          state_nxt = EXECUTER;
                    OP_ITYPE:          state_nxt = EXECUTEI;
                    OP_BRANCH:         state_nxt = BEQ;
                    OP_JAL:            state_nxt = JAL;
                    default:           state_nxt = ILLEGAL;
                endcase
            end
            MEMADR: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                state_nxt = op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc  = 1'b1;
                mem_req = 1'b1;
                if (mem_ready) state_nxt = MEMWB;
            end
            MEMWB: begin
                ResultSrc     = RES_DATA;
                reg_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
            MEMWRITE: begin
                AdrSrc        = 1'b1;
                mem_req       = 1'b1;
                mem_write_raw = 1'b1;
                if (mem_ready) state_nxt = FETCH;
            end
            EXECUTER: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            EXECUTEI: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_IMM;
                alu_op    = ALUOP_FUNCT;
                state_nxt = ALUWB;
            end
            ALUWB: begin
                ResultSrc     = RES_ALUOUT;
                reg_write_raw = 1'b1;
                state_nxt     = FETCH;
            end
            BEQ: begin
                ALUSrcA   = SRCA_RD1;
                ALUSrcB   = SRCB_RD2;
                alu_op    = ALUOP_SUB;
                ResultSrc = RES_ALUOUT;
                branch    = 1'b1;
                state_nxt = FETCH;
            end
            JAL: begin
                // PC takes the target from ALUOut while the ALU forms OldPC+4 for rd.
                ALUSrcA   = SRCA_OLDPC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALUOUT;
                pc_update = 1'b1;
                state_nxt = ALUWB;
            end
            ILLEGAL: begin
                illegal_raw = 1'b1;
                state_nxt   = HALT_ON_ILLEGAL ? ILLEGAL : FETCH;
            end
            default: state_nxt = FETCH;
        endcase
    end

    // Strobes are qualified by rst_n so an in-flight store dies with the reset edge itself.
    assign PCWrite  = rst_n & (pc_update | (branch & zero));
    assign IRWrite  = rst_n & ir_write_raw;
    assign RegWrite = rst_n & reg_write_raw;
    assign MemWrite = rst_n & mem_write_raw;
    assign illegal  = rst_n & illegal_raw;
    assign ImmSrc   = imm_src(op);

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7 & op[5]),
        .alu_control (ALUControl)
    );

`ifdef MC_PERF_CNT_EN
    logic retire;

    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BEQ) ||
                    ((state == MEMWRITE) && mem_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
            if (retire) instret_cnt <= instret_cnt + CNT_W'(1);
        end
    end
`endif

endmodule
